// File: rtl/sys_defs.sv
// Shared definitions for the completion path.
//   `FU                : log2 of the number of functional units
//   CDB_W              : number of completion (CDB) slots per cycle
//   FU_IDX             : functional-unit index enumeration
//   FU_COMPLETE_PACKET : one completion packet as produced by an FU
`ifndef SYS_DEFS_SV
`define SYS_DEFS_SV

`define FU 3

package sys_defs;

    localparam int unsigned CDB_W = 3;

    typedef enum logic [`FU-1:0] {
        ALU_1,
        ALU_2,
        ALU_3,
        MULT_1,
        MULT_2,
        LS_1,
        LS_2,
        BRANCH
    } FU_IDX;

    typedef struct packed {
        logic [7:0]  dest_tag;
        logic [15:0] value;
    } FU_COMPLETE_PACKET;

endpackage

`endif

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
// Scans req starting at start (wrapping mod NUM_FU) and grants the first
// WIDTH requesters, one-hot per slot in scan order.
// Ports:
//   req       in   NUM_FU         request vector
//   start     in   IDX_W          index with highest priority
//   grant     out  WIDTH x NUM_FU one-hot grant per slot (slot 0 first)
//   any_grant out  1              at least one grant issued
//   last_idx  out  IDX_W          index of the last granted requester
module rr_pick #(
    parameter int unsigned NUM_FU = 8,
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned IDX_W  = 3
) (
    input  logic [NUM_FU-1:0]            req,
    input  logic [IDX_W-1:0]             start,
    output logic [WIDTH-1:0][NUM_FU-1:0] grant,
    output logic                         any_grant,
    output logic [IDX_W-1:0]             last_idx
);

    localparam int unsigned SLOT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    always_comb begin
        int unsigned        cnt;
        int unsigned        pos;
        logic [IDX_W-1:0]   idx;
        logic [SLOT_W-1:0]  slot;
        grant     = '0;
        any_grant = 1'b0;
        last_idx  = '0;
        cnt       = 0;
        pos       = 0;
        idx       = '0;
        slot      = '0;
        for (int unsigned j = 0; j < NUM_FU; j++) begin
            pos = (32'(start) + j) % NUM_FU;
            idx = IDX_W'(pos);
            if (req[idx] && (cnt < WIDTH)) begin
                slot              = SLOT_W'(cnt);
                grant[slot][idx]  = 1'b1;
                last_idx          = idx;
                any_grant         = 1'b1;
                cnt               = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/complete_arbiter.sv
// Completion arbiter: grants up to WIDTH FU completions per cycle onto the
// registered CDB, round-robin, and back-pressures the losers.
// Optional feature macro: COMPLETE_STALL_CNT_EN (adds the stall_count port).
// Ports:
//   clock          in   1             system clock
//   reset          in   1             asynchronous active-low reset
//   squash         in   1             flush: no grants, no stalls, bus cleared
//   fu_finish      in   NUM_FU        FU i has a completion packet
//   fu_c_packet    in   NUM_FU*PKT_W  packet of FU i
//   complete_stall out  NUM_FU        FU i not accepted this cycle
//   cdb_valid      out  WIDTH         slot k holds a completion
//   cdb_packet     out  WIDTH*PKT_W   registered completion packets
//   cdb_fu_idx     out  WIDTH*IDX_W   source FU index per slot
//   stall_count    out  32            cumulative stalls (feature builds only)
module complete_arbiter
    import sys_defs::*;
#(
    parameter int unsigned NUM_FU = 2**`FU,
    parameter int unsigned WIDTH  = CDB_W,
    parameter int unsigned PKT_W  = $bits(FU_COMPLETE_PACKET),
    parameter int unsigned IDX_W  = $clog2(NUM_FU)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     squash,
    input  logic [NUM_FU-1:0]        fu_finish,
    input  logic [NUM_FU*PKT_W-1:0]  fu_c_packet,
    output logic [NUM_FU-1:0]        complete_stall,
    output logic [WIDTH-1:0]         cdb_valid,
    output logic [WIDTH*PKT_W-1:0]   cdb_packet,
    output logic [WIDTH*IDX_W-1:0]   cdb_fu_idx
`ifdef COMPLETE_STALL_CNT_EN
    ,
    output logic [31:0]              stall_count
`endif
);

    logic [IDX_W-1:0]             rr_ptr;
    logic [WIDTH-1:0][NUM_FU-1:0] grant_oh;
    logic                         any_grant;
    logic [IDX_W-1:0]             last_idx;
    logic [NUM_FU-1:0]            grant_vec;
    logic [WIDTH-1:0]             nxt_valid;
    logic [WIDTH*PKT_W-1:0]       nxt_packet;
    logic [WIDTH*IDX_W-1:0]       nxt_fu_idx;
    logic [IDX_W-1:0]             rr_nxt;

    rr_pick #(
        .NUM_FU (NUM_FU),
        .WIDTH  (WIDTH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req       (fu_finish),
        .start     (rr_ptr),
        .grant     (grant_oh),
        .any_grant (any_grant),
        .last_idx  (last_idx)
    );

    // Squash overrides every grant; stall is released too since the FUs are
    // flushed by the same squash. While in reset nothing may be accepted.
    always_comb begin
        grant_vec = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            grant_vec = grant_vec | grant_oh[k];
        end
        if (!reset) begin
            complete_stall = '1;
        end else if (squash) begin
            complete_stall = '0;
        end else begin
            complete_stall = fu_finish & ~grant_vec;
        end
    end

    // Slot muxing from the one-hot grants; unfilled slots stay all-zero.
    always_comb begin
        nxt_valid  = '0;
        nxt_packet = '0;
        nxt_fu_idx = '0;
        if (!squash) begin
            for (int unsigned k = 0; k < WIDTH; k++) begin
                for (int unsigned i = 0; i < NUM_FU; i++) begin
                    if (grant_oh[k][i]) begin
                        nxt_valid[k]                   = 1'b1;
                        nxt_packet[k*PKT_W +: PKT_W]   = fu_c_packet[i*PKT_W +: PKT_W];
                        nxt_fu_idx[k*IDX_W +: IDX_W]   = IDX_W'(i);
                    end
                end
            end
        end
    end

    assign rr_nxt = IDX_W'((32'(last_idx) + 1) % NUM_FU);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb_valid  <= '0;
            cdb_packet <= '0;
            cdb_fu_idx <= '0;
            rr_ptr     <= '0;
        end else begin
            cdb_valid  <= nxt_valid;
            cdb_packet <= nxt_packet;
            cdb_fu_idx <= nxt_fu_idx;
            if (any_grant && !squash) begin
                rr_ptr <= rr_nxt;
            end
        end
    end

`ifdef COMPLETE_STALL_CNT_EN
    // Free-running, wraps mod 2^32, unaffected by squash.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else begin
            stall_count <= stall_count + 32'($countones(complete_stall));
        end
    end
`else
    // No stall counter in this build.
`endif

endmodule

// File: doc/complete_arbiter.md
Name: complete_arbiter

Overview:
- Consumer end of the FU completion handshake. Receives fu_finish / fu_c_packet from all functional units and grants up to WIDTH completions per cycle onto the registered CDB/complete bus.
- Back-pressures every losing FU with complete_stall.
- Sits between the execution stage and the complete stage / ROB / RS wakeup.

Parameters:
- NUM_FU, 8, number of FU completion requesters (2**`FU; ALU_1..3, MULT_1..2, LS_1..2, BRANCH).
- WIDTH, 3, completion slots per cycle (CDB width).
- PKT_W, $bits(FU_COMPLETE_PACKET), width of one completion packet.
- IDX_W, $clog2(NUM_FU), width of an FU index.

Ports:
- clock  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- squash  in  1  mispredict flush from retire; kills the bus contents.
- fu_finish  in  NUM_FU  FU i holds a valid completion packet.
- fu_c_packet  in  NUM_FU*PKT_W  packet of FU i; stable while stalled.
- complete_stall  out  NUM_FU  FU i is not accepted this cycle and must hold.
- cdb_valid  out  WIDTH  slot k holds a completion.
- cdb_packet  out  WIDTH*PKT_W  registered completion packets.
- cdb_fu_idx  out  WIDTH*IDX_W  source FU index per slot.
- stall_count  out  32  only with COMPLETE_STALL_CNT_EN, see Optional Feature.

Behaviour:
- Grant (combinational, same cycle): start at rr_ptr and scan i = rr_ptr, rr_ptr+1, ... mod NUM_FU. The first min(WIDTH, popcount(fu_finish)) requesters are granted. The first granted goes to slot 0, the next to slot 1, and so on.
- complete_stall[i] = fu_finish[i] & ~grant[i]. A requester with stall=0 has transferred in that cycle. Non-requesters always see stall=0.
- Latency: a packet granted in cycle t appears on cdb_* in cycle t+1, registered, and is held exactly one cycle.
- Unfilled slots: cdb_valid[k]=0; cdb_packet and cdb_fu_idx for that slot are zero.
- rr_ptr update: when at least one grant occurs, rr_ptr <= (index of last granted FU + 1) mod NUM_FU. With no grants, rr_ptr holds.
- Fairness: any continuously requesting FU is granted within ceil(NUM_FU/WIDTH) = 3 cycles at defaults.
- Grant count of 0..WIDTH: all requests granted, no stalls.
- Grant count > WIDTH: exactly WIDTH grants, and exactly popcount-WIDTH stalls.
- squash=1 in cycle t:
  - grant is forced to 0 and complete_stall to 0, so stalled FUs are released; the FUs are flushed by the same squash.
  - cdb_valid <= 0 at t+1.
  - rr_ptr holds.
- Squash and requests in the same cycle: squash wins and nothing is forwarded.
- Reset (reset==0, any time, asynchronous):
  - cdb_valid=0, cdb_packet=0, cdb_fu_idx=0, rr_ptr=0, stall_count=0.
  - complete_stall is forced to all ones while reset is low, so no packet is accepted.
  - Normal arbitration resumes on the first posedge after reset deasserts.
- No internal buffering: the block holds no state other than rr_ptr, the output registers and the counter. Packets are never dropped or duplicated.

Optional Feature:
- Macro COMPLETE_STALL_CNT_EN.
- Defined:
  - stall_count is a 32-bit counter that increments by popcount(complete_stall) each cycle reset is high.
  - It wraps mod 2^32 and is not cleared by squash.
- Undefined: the stall_count port and counter are absent; arbitration behaviour is identical.

Decomposition:
- Shared package (sys_defs): FU_COMPLETE_PACKET, the FU index enum (ALU_1..BRANCH), `FU and the CDB width constant.
- One sub-module, rr_pick: combinational rotating-priority picker.
  - Inputs: request vector and start pointer.
  - Outputs: WIDTH one-hot grants in slot order, plus the last-granted index.
- The top level holds the registers, stall logic, squash and counter.

Test Plan:
- Reset low with fu_finish=8'hFF -> complete_stall=8'hFF and cdb_valid=0. Release reset, hold 8'hFF -> grants to FU 0,1,2; stall=8'hF8; next cycle cdb_fu_idx={2,1,0} and cdb_valid=3'b111.
- Hold fu_finish=8'hFF across 3 cycles -> granted sets {0,1,2}, {3,4,5}, {6,7,0}; rr_ptr goes 0→3→6→1.
- fu_finish=8'b1000_0001 with rr_ptr=6 -> slot0=FU7, slot1=FU0, no stalls; cdb_valid=3'b011 one cycle later.
- fu_finish=8'hFF with squash=1 -> complete_stall=0 and cdb_valid=0 next cycle; rr_ptr unchanged.
- Stalled FU4 holds packet 0xABCD -> the same 0xABCD appears on cdb once FU4 is granted; it appears exactly once.
- With COMPLETE_STALL_CNT_EN, drive 8'hFF for 4 cycles -> stall_count=20.
